udp_checksum_fifo_reader: RTL and testbench

Read-side engine for the 32-bit UDP checksum FIFO on the UDP TX path. The upstream builder writes the full UDP datagram (header plus payload) into the FIFO. It computes the checksum while doing so, then pulses pkt_start with the length and checksum. This block pops the FIFO and serialises it big-endian to a byte stream for the MAC/IP framer. On the way it overwrites UDP header bytes 6–7 with the final checksum.

---
 rtl/udp_checksum_fifo_reader.sv | 127 ++++++++++++
 tb/tb_udp_checksum_fifo_reader.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_checksum_fifo_reader.sv
// Pops a datagram that is fully resident in a 32-bit FIFO and streams it as big-endian bytes.
// Header bytes 6-7 are replaced by the checksum that was latched at pkt_start.
module udp_checksum_fifo_reader #(
    parameter int DATA_WIDTH     = 32,
    parameter int LEN_WIDTH      = 16,
    parameter bit CSUM_INSERT_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pkt_start,
    input  logic [LEN_WIDTH-1:0]  pkt_len,
    input  logic [15:0]           pkt_csum,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_empty,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  tx_last,
    output logic                  busy,
    output logic                  done,
    output logic                  len_err,
    output logic                  underrun,
    output logic [1:0]            fsm_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

    state_t                  state, state_n;
    logic [LEN_WIDTH-1:0]    len_r, byte_cnt;
    logic [15:0]             csum_r;
    logic [LEN_WIDTH-2:0]    words_left;
    logic [DATA_WIDTH-1:0]   cur, nxt;
    logic                    cur_valid, nxt_valid, rd_pend;
    logic                    len_err_r, underrun_r;
    logic                    is_last, accept, cur_release, cur_take, start_ok;

    // tx handshake: a byte transfers on any cycle with tx_valid && tx_ready; while tx_valid
    // is high and tx_ready low, tx_data and tx_last hold their values.
    always_comb begin
        state_n     = state;
        start_ok    = (state == IDLE) && pkt_start && (pkt_len >= LEN_WIDTH'(8));
        tx_valid    = (state == RUN) && cur_valid;
        is_last     = (byte_cnt == len_r - LEN_WIDTH'(1));
        accept      = tx_valid && tx_ready;
        cur_release = accept && ((byte_cnt[1:0] == 2'd3) || is_last);
        cur_take    = !cur_valid || cur_release;
        tx_last     = tx_valid && is_last;
        // A freed nxt slot in the same cycle lets the fetch run back-to-back with the output.
        rd_en       = (state == RUN) && (words_left != '0) && !rd_empty && !rd_pend
                      && (!nxt_valid || cur_release);
        case (byte_cnt[1:0])
            2'd0:    tx_data = cur[31:24];
            2'd1:    tx_data = cur[23:16];
            2'd2:    tx_data = cur[15:8];
            default: tx_data = cur[7:0];
        endcase
        if (CSUM_INSERT_EN && (byte_cnt == LEN_WIDTH'(6))) tx_data = csum_r[15:8];
        if (CSUM_INSERT_EN && (byte_cnt == LEN_WIDTH'(7))) tx_data = csum_r[7:0];
        case (state)
            IDLE:    if (start_ok) state_n = RUN;
            RUN:     if (accept && is_last) state_n = FLUSH;
            FLUSH:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
        busy      = (state != IDLE);
        done      = (state == FLUSH);
        len_err   = len_err_r;
        underrun  = underrun_r;
        fsm_state = state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            len_r      <= '0;
            csum_r     <= '0;
            words_left <= '0;
            byte_cnt   <= '0;
            cur        <= '0;
            nxt        <= '0;
            cur_valid  <= 1'b0;
            nxt_valid  <= 1'b0;
            rd_pend    <= 1'b0;
            len_err_r  <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            state      <= state_n;
            len_err_r  <= (state == IDLE) && pkt_start && (pkt_len < LEN_WIDTH'(8));
            underrun_r <= cur_release && !is_last && !nxt_valid && !rd_pend;
            if (start_ok) begin
                len_r      <= pkt_len;
                csum_r     <= (pkt_csum == 16'h0000) ? 16'hFFFF : pkt_csum;
                // Extra top bit keeps a 0xFFFF length from wrapping before the shift.
                words_left <= (LEN_WIDTH-1)'(({1'b0, pkt_len} + (LEN_WIDTH+1)'(3)) >> 2);
                byte_cnt   <= '0;
                cur_valid  <= 1'b0;
                nxt_valid  <= 1'b0;
                rd_pend    <= 1'b0;
            end else if (state == RUN) begin
                rd_pend <= rd_en;
                if (rd_en) words_left <= words_left - (LEN_WIDTH-1)'(1);
                if (accept) byte_cnt <= byte_cnt + LEN_WIDTH'(1);
                if (accept && is_last) begin
                    cur_valid <= 1'b0;
                    nxt_valid <= 1'b0;
                end else if (cur_take) begin
                    if (nxt_valid) begin
                        cur       <= nxt;
                        cur_valid <= 1'b1;
                        nxt_valid <= rd_pend;
                        if (rd_pend) nxt <= rd_data;
                    end else if (rd_pend) begin
                        cur       <= rd_data;
                        cur_valid <= 1'b1;
                    end else begin
                        cur_valid <= 1'b0;
                    end
                end else if (rd_pend) begin
                    nxt       <= rd_data;
                    nxt_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_udp_checksum_fifo_reader.sv
// Directed datagrams through a queue-based FIFO model; every accepted byte is scored against
// a byte list built from the datagram words, length and checksum.
module tb_udp_checksum_fifo_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pkt_start = 1'b0;
    logic [15:0] pkt_len = '0;
    logic [15:0] pkt_csum = '0;
    logic        rd_en;
    logic [31:0] rd_data = '0;
    logic        rd_empty = 1'b1;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        tx_last;
    logic        busy, done, len_err, underrun;
    logic [1:0]  fsm_state;

    always #5 clk = ~clk;

    udp_checksum_fifo_reader dut (
        .clk(clk), .rst(rst), .pkt_start(pkt_start), .pkt_len(pkt_len), .pkt_csum(pkt_csum),
        .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
        .busy(busy), .done(done), .len_err(len_err), .underrun(underrun), .fsm_state(fsm_state)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // FIFO model: the pop happens just after the edge that sampled rd_en, so rd_data is
    // valid during the following cycle.
    logic [31:0] fifo_q[$];
    logic        pop_now = 1'b0;
    int          rd_cnt = 0;

    always @(negedge clk) begin
        if (!rst && rd_en) begin
            check("rd_en_while_empty", {31'd0, rd_empty}, 32'd0);
            pop_now = 1'b1;
        end
    end

    always @(posedge clk) begin
        if (pop_now) begin
            #1;
            pop_now = 1'b0;
            if (fifo_q.size() != 0) begin
                rd_data = fifo_q.pop_front();
                rd_cnt++;
            end
            rd_empty = (fifo_q.size() == 0);
        end
    end

    // Datagram model and scoreboard.
    logic [31:0] pkt_words[$];
    logic [8:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic [8:0]  exp_e;
    logic        prev_hold = 1'b0;
    logic        prev_last_hs = 1'b0;
    logic [7:0]  prev_data = '0;
    logic        prev_last = 1'b0;
    int          hs_cnt = 0, uf_cnt = 0, first_v_cyc = -1, last_hs_cyc = 0, start_cyc = 0;

    task automatic build_expected(input int len, input logic [15:0] csum);
        logic [15:0] c;
        logic [31:0] w;
        logic [7:0]  b;
        c = (csum == 16'h0000) ? 16'hFFFF : csum;
        for (int i = 0; i < len; i++) begin
            w = pkt_words[i / 4];
            b = w[31 - 8 * (i % 4) -: 8];
            if (i == 6) b = c[15:8];
            if (i == 7) b = c[7:0];
            exp_q.push_back({(i == len - 1), b});
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_hold    = 1'b0;
            prev_last_hs = 1'b0;
        end else begin
            check("done_pulse", {31'd0, done}, {31'd0, prev_last_hs});
            if (prev_hold)
                check("hold_stable", {22'd0, tx_valid, tx_last, tx_data}, {22'd0, 1'b1, prev_last, prev_data});
            if (underrun) begin
                uf_cnt++;
                check("underrun_valid_low", {31'd0, tx_valid}, 32'd0);
            end
            if (tx_valid && first_v_cyc < 0) first_v_cyc = cyc;
            prev_last_hs = 1'b0;
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {23'd0, tx_last, tx_data}, 32'h1FF);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("tx_byte", {23'd0, tx_last, tx_data}, {23'd0, exp_e});
                    prev_last_hs = exp_e[8];
                end
                got_q.push_back(tx_data);
                hs_cnt++;
                last_hs_cyc = cyc;
            end
            prev_hold = tx_valid && !tx_ready;
            prev_data = tx_data;
            prev_last = tx_last;
        end
    end

    task automatic push_words(input int first, input int n);
        for (int i = first; i < first + n; i++) fifo_q.push_back(pkt_words[i]);
        rd_empty = (fifo_q.size() == 0);
    endtask

    task automatic start_pkt(input logic [15:0] len, input logic [15:0] csum);
        rd_cnt      = 0;
        hs_cnt      = 0;
        uf_cnt      = 0;
        first_v_cyc = -1;
        got_q.delete();
        start_cyc   = cyc;
        pkt_start   = 1'b1;
        pkt_len     = len;
        pkt_csum    = csum;
        tick(1);
        pkt_start   = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input bit toggle_ready);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            if (toggle_ready) tx_ready = ~tx_ready;
            tick(1);
            n++;
        end
        check("idle_timeout", {31'd0, (busy || exp_q.size() != 0)}, 32'd0);
        tx_ready = 1'b1;
        tick(1);
    endtask

    task automatic check_all_zero(input string name);
        check(name, {13'd0, rd_en, tx_data, tx_valid, tx_last, busy, done, len_err, underrun, fsm_state},
              32'd0);
    endtask

    logic [63:0] lit8;

    initial begin
        // Reset state
        tick(3);
        check_all_zero("reset_outputs");
        rst = 1'b0;
        tick(2);

        // Header only
        pkt_words = '{32'h1234_5678, 32'h0008_ABCD};
        push_words(0, 2);
        build_expected(8, 16'h1A2B);
        start_pkt(16'd8, 16'h1A2B);
        wait_idle(100, 1'b0);
        check("hdr_rd_count", rd_cnt, 32'd2);
        check("hdr_byte_count", hs_cnt, 32'd8);
        lit8 = 64'h1234_5678_0008_1A2B;
        for (int i = 0; i < 8 && i < got_q.size(); i++)
            check("hdr_literal", {24'd0, got_q[i]}, {24'd0, lit8[63 - 8 * i -: 8]});

        // Partial final word, no backpressure
        pkt_words = '{32'h1122_3344, 32'h000D_0000, 32'h5566_7788, 32'h99AA_BBCC};
        push_words(0, 4);
        build_expected(13, 16'hBEEF);
        start_pkt(16'd13, 16'hBEEF);
        wait_idle(100, 1'b0);
        check("part_first_valid_lat", first_v_cyc - start_cyc, 32'd3);
        check("part_no_gaps", last_hs_cyc - first_v_cyc, 32'd12);
        check("part_rd_count", rd_cnt, 32'd4);
        check("part_byte_count", hs_cnt, 32'd13);
        if (got_q.size() == 13) begin
            check("part_last_byte", {24'd0, got_q[12]}, 32'h99);
            check("part_csum_hi", {24'd0, got_q[6]}, 32'hBE);
            check("part_csum_lo", {24'd0, got_q[7]}, 32'hEF);
        end

        // Zero checksum under 1010 backpressure
        pkt_words = '{32'hA0A1_A2A3, 32'h000A_5555, 32'hB0B1_0000};
        push_words(0, 3);
        build_expected(10, 16'h0000);
        start_pkt(16'd10, 16'h0000);
        wait_idle(200, 1'b1);
        check("zcs_byte_count", hs_cnt, 32'd10);
        if (got_q.size() == 10) begin
            check("zcs_byte6", {24'd0, got_q[6]}, 32'hFF);
            check("zcs_byte7", {24'd0, got_q[7]}, 32'hFF);
        end

        // FIFO starvation
        pkt_words = '{32'h0102_0304, 32'h000C_0506, 32'h0708_090A};
        push_words(0, 1);
        build_expected(12, 16'h4321);
        start_pkt(16'd12, 16'h4321);
        tick(10);
        check("starve_valid_low", {31'd0, tx_valid}, 32'd0);
        check("starve_bytes_before", hs_cnt, 32'd4);
        check("starve_underrun_seen", uf_cnt, 32'd1);
        push_words(1, 2);
        wait_idle(100, 1'b0);
        check("starve_underrun_once", uf_cnt, 32'd1);
        check("starve_byte_count", hs_cnt, 32'd12);
        check("starve_rd_count", rd_cnt, 32'd3);

        // Too-short length is dropped
        start_pkt(16'd5, 16'h1111);
        check("short_len_err", {31'd0, len_err}, 32'd1);
        check("short_busy", {31'd0, busy}, 32'd0);
        tick(1);
        check("short_len_err_once", {31'd0, len_err}, 32'd0);
        check("short_busy_after", {31'd0, busy}, 32'd0);

        // pkt_start during an active datagram is ignored
        pkt_words = '{32'hCAFE_BABE, 32'h0008_0000};
        push_words(0, 2);
        build_expected(8, 16'h0102);
        start_pkt(16'd8, 16'h0102);
        tick(2);
        pkt_start = 1'b1;
        pkt_len   = 16'd20;
        pkt_csum  = 16'h9999;
        tick(1);
        pkt_start = 1'b0;
        wait_idle(100, 1'b0);
        check("ovl_byte_count", hs_cnt, 32'd8);
        check("ovl_rd_count", rd_cnt, 32'd2);
        if (got_q.size() == 8) check("ovl_csum", {16'd0, got_q[6], got_q[7]}, 32'h0102);
        tick(3);
        check("ovl_stays_idle", {30'd0, busy, len_err}, 32'd0);

        // Reset mid-datagram, then a fresh datagram after a FIFO reset
        pkt_words = '{32'h1011_1213, 32'h0010_1415, 32'h1819_1A1B, 32'h1C1D_1E1F};
        push_words(0, 4);
        build_expected(16, 16'h7777);
        start_pkt(16'd16, 16'h7777);
        for (int n = 0; n < 50 && hs_cnt < 5; n++) tick(1);
        check("rst_reached_byte5", hs_cnt, 32'd5);
        rst = 1'b1;
        tick(1);
        check_all_zero("rst_mid_outputs");
        fifo_q.delete();
        exp_q.delete();
        pop_now  = 1'b0;
        rd_empty = 1'b1;
        rst = 1'b0;
        tick(2);
        pkt_words = '{32'hDEAD_BEEF, 32'h0009_0000, 32'h4200_0000};
        push_words(0, 3);
        build_expected(9, 16'h55AA);
        start_pkt(16'd9, 16'h55AA);
        wait_idle(100, 1'b0);
        check("post_rst_byte_count", hs_cnt, 32'd9);
        if (got_q.size() == 9) begin
            check("post_rst_first", {24'd0, got_q[0]}, 32'hDE);
            check("post_rst_last", {24'd0, got_q[8]}, 32'h42);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
